// File: rtl/mp_comparator_msw_if.sv
// rtl/mp_comparator_msw_if.sv - request/result bundle for the word-serial magnitude comparator
interface mp_comparator_msw_if #(
    parameter int OPERAND_WIDTH = 512
);
    logic                     iStart;
    logic                     iSigned;
    logic [OPERAND_WIDTH-1:0] iOpA;
    logic [OPERAND_WIDTH-1:0] iOpB;
    logic                     oGt;
    logic                     oEq;
    logic                     oLt;
    logic                     oBusy;
    logic                     oDone;

    modport master (
        output iStart, iSigned, iOpA, iOpB,
        input  oGt, oEq, oLt, oBusy, oDone
    );

    modport slave (
        input  iStart, iSigned, iOpA, iOpB,
        output oGt, oEq, oLt, oBusy, oDone
    );
endinterface

// File: rtl/mp_comparator_msw.sv
// rtl/mp_comparator_msw.sv - MSW-first word-serial magnitude comparator with early exit
module mp_comparator_msw #(
    parameter int OPERAND_WIDTH = 512,
    parameter int WORD_WIDTH    = 32,
    parameter int N_WORDS       = OPERAND_WIDTH / WORD_WIDTH
) (
    input  logic                iClk,
    input  logic                iRst_n,
    mp_comparator_msw_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(N_WORDS) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state, stateNext;
    logic [OPERAND_WIDTH-1:0] regA, regANext;
    logic [OPERAND_WIDTH-1:0] regB, regBNext;
    logic                     regSigned, regSignedNext;
    logic [CNT_WIDTH-1:0]     cnt, cntNext;
    logic                     gt, gtNext;
    logic                     eq, eqNext;
    logic                     lt, ltNext;

    logic [WORD_WIDTH-1:0]        wA, wB;
    logic signed [WORD_WIDTH-1:0] sA, sB;
    logic                         useSigned;
    logic                         wordEq;
    logic                         wordGt;

    assign wA = regA[OPERAND_WIDTH-1 -: WORD_WIDTH];
    assign wB = regB[OPERAND_WIDTH-1 -: WORD_WIDTH];
    assign sA = wA;
    assign sB = wB;
    // Only the most significant word carries the sign; lower words are magnitude digits.
    assign useSigned = regSigned && (cnt == '0);
    assign wordEq    = (wA == wB);
    assign wordGt    = useSigned ? (sA > sB) : (wA > wB);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            regA      <= '0;
            regB      <= '0;
            regSigned <= 1'b0;
            cnt       <= '0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            state     <= stateNext;
            regA      <= regANext;
            regB      <= regBNext;
            regSigned <= regSignedNext;
            cnt       <= cntNext;
            gt        <= gtNext;
            eq        <= eqNext;
            lt        <= ltNext;
        end
    end

    always_comb begin
        stateNext     = state;
        regANext      = regA;
        regBNext      = regB;
        regSignedNext = regSigned;
        cntNext       = cnt;
        gtNext        = gt;
        eqNext        = eq;
        ltNext        = lt;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    regANext      = bus.iOpA;
                    regBNext      = bus.iOpB;
                    regSignedNext = bus.iSigned;
                    cntNext       = '0;
                    gtNext        = 1'b0;
                    eqNext        = 1'b0;
                    ltNext        = 1'b0;
                    stateNext     = COMPARE;
                end
            end
            COMPARE: begin
                if (!wordEq) begin
                    gtNext    = wordGt;
                    ltNext    = !wordGt;
                    stateNext = DONE;
                end else if (cnt == LAST_WORD) begin
                    eqNext    = 1'b1;
                    stateNext = DONE;
                end else begin
                    regANext = regA << WORD_WIDTH;
                    regBNext = regB << WORD_WIDTH;
                    cntNext  = cnt + 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.oGt   = gt;
    assign bus.oEq   = eq;
    assign bus.oLt   = lt;
    assign bus.oBusy = (state != IDLE);
    assign bus.oDone = (state == DONE);
endmodule

// File: tb/tb_mp_comparator_msw.sv
// tb/tb_mp_comparator_msw.sv - directed table, corner sequences and random sweep for mp_comparator_msw
module tb_mp_comparator_msw;
    localparam int OW = 128;
    localparam int WW = 32;
    localparam int NW = OW / WW;

    logic iClk;
    logic iRst_n;
    int   nChecks = 0;
    int   nErrors = 0;

    mp_comparator_msw_if #(.OPERAND_WIDTH(OW)) bus ();

    mp_comparator_msw #(
        .OPERAND_WIDTH(OW),
        .WORD_WIDTH   (WW)
    ) dut (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .bus   (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        bit            s;
        logic [2:0]    expFlags;
        int            expCyc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-operand compare plus position of the most significant differing word.
    task automatic refCmp(input logic [OW-1:0] a, input logic [OW-1:0] b, input bit s,
                          output logic [2:0] flags, output int cyc);
        logic signed [OW-1:0] sa, sb;
        logic [OW-1:0] x;
        int p;
        sa = a;
        sb = b;
        if (s) flags = (sa > sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
        else   flags = (a > b)   ? 3'b100 : (a == b)   ? 3'b010 : 3'b001;
        x = a ^ b;
        p = -1;
        for (int i = OW - 1; i >= 0; i--) begin
            if (x[i]) begin
                p = i;
                break;
            end
        end
        cyc = (p < 0) ? NW + 1 : ((OW - 1 - p) / WW) + 2;
    endtask

    // Issues one start and returns the cycle oDone appears in (cycle 0 = start sampled).
    task automatic runOp(input logic [OW-1:0] a, input logic [OW-1:0] b, input bit s,
                         output int cyc, output logic [2:0] flags, output logic busyAtDone);
        @(negedge iClk);
        bus.iOpA    = a;
        bus.iOpB    = b;
        bus.iSigned = s;
        bus.iStart  = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        bus.iStart  = 1'b0;
        bus.iOpA    = {$urandom, $urandom, $urandom, $urandom};
        bus.iOpB    = {$urandom, $urandom, $urandom, $urandom};
        bus.iSigned = ~s;
        cyc = 1;
        while (!bus.oDone && cyc < 20) begin
            @(negedge iClk);
            cyc++;
        end
        flags      = {bus.oGt, bus.oEq, bus.oLt};
        busyAtDone = bus.oBusy;
    endtask

    vec_t vecs[5];
    int          cyc, expCyc, doneCount;
    logic [2:0]  flags, expFlags;
    logic        busy;
    logic [OW-1:0] ra, rb;

    initial begin
        vecs[0] = '{128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                    128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0, 3'b010, 5};
        vecs[1] = '{128'h2 << 96, 128'h1 << 96, 1'b0, 3'b100, 2};
        vecs[2] = '{128'h5, 128'h6, 1'b0, 3'b001, 5};
        vecs[3] = '{128'h1 << 127, 128'h1, 1'b0, 3'b100, 2};
        vecs[4] = '{128'h1 << 127, 128'h1, 1'b1, 3'b001, 2};

        iRst_n      = 1'b0;
        bus.iStart  = 1'b0;
        bus.iSigned = 1'b0;
        bus.iOpA    = '0;
        bus.iOpB    = '0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("reset_outputs", {59'd0, bus.oGt, bus.oEq, bus.oLt, bus.oBusy, bus.oDone}, 64'd0);
        iRst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].s, cyc, flags, busy);
            check($sformatf("vec%0d_cycle", i), cyc, vecs[i].expCyc);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].expFlags);
            check($sformatf("vec%0d_busy", i), busy, 1'b1);
        end

        // Flags must hold through idle cycles with no new start.
        repeat (4) @(negedge iClk);
        check("flags_hold", {bus.oGt, bus.oEq, bus.oLt, bus.oBusy, bus.oDone}, 5'b00100);

        // Reset one cycle after accepting a start aborts without a done pulse.
        @(negedge iClk);
        bus.iOpA   = 128'h1;
        bus.iOpB   = 128'h0;
        bus.iSigned = 1'b0;
        bus.iStart = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        bus.iStart = 1'b0;
        iRst_n     = 1'b0;
        doneCount  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge iClk);
            if (bus.oDone) doneCount++;
        end
        check("abort_no_done", doneCount, 0);
        check("abort_outputs", {bus.oGt, bus.oEq, bus.oLt, bus.oBusy, bus.oDone}, 5'b00000);
        iRst_n = 1'b1;
        runOp(128'h1, 128'h0, 1'b0, cyc, flags, busy);
        check("after_abort_cycle", cyc, 5);
        check("after_abort_flags", flags, 3'b100);

        // iStart held high: restarts only from IDLE, one done per accepted start.
        @(negedge iClk);
        bus.iOpA    = 128'hDEAD;
        bus.iOpB    = 128'hDEAD;
        bus.iSigned = 1'b0;
        bus.iStart  = 1'b1;
        doneCount   = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge iClk);
            if (c == 9) bus.iStart = 1'b0;
            if (bus.oDone) doneCount++;
        end
        check("held_start_dones", doneCount, 2);
        check("held_start_flags", {bus.oGt, bus.oEq, bus.oLt, bus.oBusy}, 4'b0100);

        for (int n = 0; n < 60; n++) begin
            int k;
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = ra;
            k  = $urandom_range(0, NW);
            for (int w = k; w < NW; w++) begin
                if (w == k || $urandom_range(0, 1) == 1)
                    rb[OW-1-w*WW -: WW] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                ra[OW-1] = ~ra[OW-1];
            end
            refCmp(ra, rb, n[0], expFlags, expCyc);
            runOp(ra, rb, n[0], cyc, flags, busy);
            check($sformatf("rand%0d_cycle", n), cyc, expCyc);
            check($sformatf("rand%0d_flags", n), flags, expFlags);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
